// File: rtl/mips_exec_unit.sv
// mips_exec_unit
//   Single-cycle MIPS execute slice: instruction decode, 32-entry register
//   file and ALU. The PC, instruction memory and data memory live outside.
//
// Ports:
//   clk            rising-edge clock for register file writes
//   reset          asynchronous active-high reset; clears the register file
//   i_enable       commit qualifier for register writes and memory writes
//   i_instr        current instruction word
//   i_mem_rd_data  load data returned by data memory
//   o_mem_wr_en    data-memory write strobe (sw, qualified by i_enable)
//   o_mem_addr     ALU result, used as the memory address
//   o_mem_wr_data  register read port B (rt), used as store data
//   o_alu_zero     ALU result equals zero
//   o_branch_taken beq decoded and operands equal
//   o_jump         j decoded
//   o_imm_ext      sign-extended i_instr[15:0]

module mips_exec_unit #(
    parameter int DATA_WIDTH_P      = 32,
    parameter int ADDR_WIDTH_P      = 5,
    parameter int ALU_CNTRL_WIDTH_P = 3,
    parameter int FUNCT_WIDTH_P     = 6,
    parameter int OP_WIDTH_P        = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_enable,
    input  logic [DATA_WIDTH_P-1:0] i_instr,
    input  logic [DATA_WIDTH_P-1:0] i_mem_rd_data,
    output logic                    o_mem_wr_en,
    output logic [DATA_WIDTH_P-1:0] o_mem_addr,
    output logic [DATA_WIDTH_P-1:0] o_mem_wr_data,
    output logic                    o_alu_zero,
    output logic                    o_branch_taken,
    output logic                    o_jump,
    output logic [DATA_WIDTH_P-1:0] o_imm_ext
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH_P;

    localparam logic [OP_WIDTH_P-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_WIDTH_P-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_WIDTH_P-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_WIDTH_P-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_WIDTH_P-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_WIDTH_P-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_WIDTH_P-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_WIDTH_P-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_WIDTH_P-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_WIDTH_P-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_WIDTH_P-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_SLT = 3'b111;

    // Instruction fields
    logic [OP_WIDTH_P-1:0]    opcode;
    logic [FUNCT_WIDTH_P-1:0] funct;
    logic [ADDR_WIDTH_P-1:0]  rs_addr;
    logic [ADDR_WIDTH_P-1:0]  rt_addr;
    logic [ADDR_WIDTH_P-1:0]  rd_addr;

    assign opcode  = i_instr[31:26];
    assign rs_addr = i_instr[25:21];
    assign rt_addr = i_instr[20:16];
    assign rd_addr = i_instr[15:11];
    assign funct   = i_instr[5:0];

    assign o_imm_ext = {{(DATA_WIDTH_P-16){i_instr[15]}}, i_instr[15:0]};

    // Decode
    logic                         reg_wr_en;
    logic                         reg_wr_addr_sel;
    logic                         alu_src_sel;
    logic                         branch;
    logic                         mem_wr_en;
    logic                         reg_wr_data_sel;
    logic                         jump;
    logic [ALU_CNTRL_WIDTH_P-1:0] alu_cntrl;

    always_comb begin
        reg_wr_en       = 1'b0;
        reg_wr_addr_sel = 1'b0;
        alu_src_sel     = 1'b0;
        branch          = 1'b0;
        mem_wr_en       = 1'b0;
        reg_wr_data_sel = 1'b0;
        jump            = 1'b0;
        alu_cntrl       = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                reg_wr_en       = 1'b1;
                reg_wr_addr_sel = 1'b1;
                case (funct)
                    FN_ADD:  alu_cntrl = ALU_ADD;
                    FN_SUB:  alu_cntrl = ALU_SUB;
                    FN_AND:  alu_cntrl = ALU_AND;
                    FN_OR:   alu_cntrl = ALU_OR;
                    FN_SLT:  alu_cntrl = ALU_SLT;
                    // Unsupported funct must not corrupt the destination
                    default: reg_wr_en = 1'b0;
                endcase
            end
            OP_LW: begin
                reg_wr_en       = 1'b1;
                alu_src_sel     = 1'b1;
                reg_wr_data_sel = 1'b1;
            end
            OP_SW: begin
                alu_src_sel = 1'b1;
                mem_wr_en   = 1'b1;
            end
            OP_BEQ: begin
                branch    = 1'b1;
                alu_cntrl = ALU_SUB;
            end
            OP_ADDI: begin
                reg_wr_en   = 1'b1;
                alu_src_sel = 1'b1;
            end
            OP_J: begin
                jump = 1'b1;
            end
            default: ;
        endcase
    end

    // Register file: reads are asynchronous; register 0 is hardwired to zero
    logic [DATA_WIDTH_P-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH_P-1:0] rs_data;
    logic [DATA_WIDTH_P-1:0] rt_data;
    logic [ADDR_WIDTH_P-1:0] wr_addr;
    logic [DATA_WIDTH_P-1:0] wr_data;
    logic [DATA_WIDTH_P-1:0] alu_result;

    assign rs_data = (reset || rs_addr == '0) ? '0 : regs[rs_addr];
    assign rt_data = (reset || rt_addr == '0) ? '0 : regs[rt_addr];
    assign wr_addr = reg_wr_addr_sel ? rd_addr : rt_addr;
    assign wr_data = reg_wr_data_sel ? i_mem_rd_data : alu_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_wr_en && i_enable && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // ALU
    function automatic logic [DATA_WIDTH_P-1:0] alu_op(
        input logic [ALU_CNTRL_WIDTH_P-1:0] code,
        input logic [DATA_WIDTH_P-1:0]      a,
        input logic [DATA_WIDTH_P-1:0]      b
    );
        logic signed [DATA_WIDTH_P-1:0] sa;
        logic signed [DATA_WIDTH_P-1:0] sb;
        sa = a;
        sb = b;
        case (code)
            ALU_ADD: alu_op = a + b;
            ALU_SUB: alu_op = a - b;
            ALU_AND: alu_op = a & b;
            ALU_OR:  alu_op = a | b;
            ALU_SLT: alu_op = {{(DATA_WIDTH_P-1){1'b0}}, (sa < sb)};
            default: alu_op = '0;
        endcase
    endfunction

    logic [DATA_WIDTH_P-1:0] alu_b;

    assign alu_b      = alu_src_sel ? o_imm_ext : rt_data;
    assign alu_result = alu_op(alu_cntrl, rs_data, alu_b);

    // Outputs
    assign o_alu_zero     = (alu_result == '0);
    assign o_mem_addr     = alu_result;
    assign o_mem_wr_data  = rt_data;
    assign o_mem_wr_en    = mem_wr_en & i_enable;
    assign o_branch_taken = branch & o_alu_zero;
    assign o_jump         = jump;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Directed bench for mips_exec_unit. A stimulus process drives one
// instruction per clock (just after the rising edge) and queues the expected
// outputs; a monitor process drains the queue on the falling edge, which is
// before the writeback edge, and compares against the DUT.

module tb_mips_exec_unit;

    logic        clk;
    logic        reset;
    logic        i_enable;
    logic [31:0] i_instr;
    logic [31:0] i_mem_rd_data;
    logic        o_mem_wr_en;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wr_data;
    logic        o_alu_zero;
    logic        o_branch_taken;
    logic        o_jump;
    logic [31:0] o_imm_ext;

    mips_exec_unit dut (
        .clk            (clk),
        .reset          (reset),
        .i_enable       (i_enable),
        .i_instr        (i_instr),
        .i_mem_rd_data  (i_mem_rd_data),
        .o_mem_wr_en    (o_mem_wr_en),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wr_data  (o_mem_wr_data),
        .o_alu_zero     (o_alu_zero),
        .o_branch_taken (o_branch_taken),
        .o_jump         (o_jump),
        .o_imm_ext      (o_imm_ext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        S_WR_EN, S_ADDR, S_WDATA, S_ZERO, S_BRANCH, S_JUMP, S_IMM
    } sel_t;

    typedef struct {
        string       name;
        sel_t        sel;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] actual(input sel_t s);
        case (s)
            S_WR_EN:  actual = {31'd0, o_mem_wr_en};
            S_ADDR:   actual = o_mem_addr;
            S_WDATA:  actual = o_mem_wr_data;
            S_ZERO:   actual = {31'd0, o_alu_zero};
            S_BRANCH: actual = {31'd0, o_branch_taken};
            S_JUMP:   actual = {31'd0, o_jump};
            default:  actual = o_imm_ext;
        endcase
    endfunction

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                logic [31:0] a;
                e = q.pop_front();
                a = actual(e.sel);
                checks++;
                if (a !== e.val) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
                end
            end
        end
    end

    task automatic drive(input logic [31:0] instr, input logic en,
                         input logic [31:0] rd, input logic rst);
        @(posedge clk);
        #1;
        i_instr       = instr;
        i_enable      = en;
        i_mem_rd_data = rd;
        reset         = rst;
    endtask

    task automatic expect_out(input string name, input sel_t s, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = s;
        e.val  = v;
        q.push_back(e);
    endtask

    initial begin
        reset         = 1'b1;
        i_enable      = 1'b0;
        i_instr       = 32'h0;
        i_mem_rd_data = 32'h0;

        // Reset state: addi $0,$1,0 reads $1 = 0 while reset is high
        drive(32'h20200000, 1'b1, 32'h0, 1'b1);
        expect_out("rst_addr", S_ADDR, 32'h0);
        expect_out("rst_zero", S_ZERO, 32'h1);
        expect_out("rst_wren", S_WR_EN, 32'h0);

        // addi $1,$0,5
        drive(32'h20010005, 1'b1, 32'h0, 1'b0);
        expect_out("addi1_addr", S_ADDR, 32'd5);
        expect_out("addi1_imm", S_IMM, 32'd5);
        expect_out("addi1_wren", S_WR_EN, 32'h0);
        // add $3,$1,$1
        drive(32'h00211820, 1'b1, 32'h0, 1'b0);
        expect_out("add_addr", S_ADDR, 32'd10);
        // sw $3,0($0)
        drive(32'hAC030000, 1'b1, 32'h0, 1'b0);
        expect_out("sw_wdata", S_WDATA, 32'd10);
        expect_out("sw_wren", S_WR_EN, 32'h1);
        expect_out("sw_addr", S_ADDR, 32'h0);
        // addi $2,$0,7
        drive(32'h20020007, 1'b1, 32'h0, 1'b0);
        expect_out("addi2_addr", S_ADDR, 32'd7);

        // R-type ops with $1=5, $2=7, dest $3
        drive(32'h00221822, 1'b1, 32'h0, 1'b0);
        expect_out("sub_addr", S_ADDR, 32'hFFFFFFFE);
        expect_out("sub_zero", S_ZERO, 32'h0);
        drive(32'h0022182A, 1'b1, 32'h0, 1'b0);
        expect_out("slt_addr", S_ADDR, 32'h1);
        expect_out("slt_zero", S_ZERO, 32'h0);
        drive(32'h00221824, 1'b1, 32'h0, 1'b0);
        expect_out("and_addr", S_ADDR, 32'd5);
        expect_out("and_zero", S_ZERO, 32'h0);
        drive(32'h00221825, 1'b1, 32'h0, 1'b0);
        expect_out("or_addr", S_ADDR, 32'd7);
        expect_out("or_zero", S_ZERO, 32'h0);

        // beq $1,$1,-1 then beq $1,$2,-1
        drive(32'h1021FFFF, 1'b1, 32'h0, 1'b0);
        expect_out("beq_eq_taken", S_BRANCH, 32'h1);
        expect_out("beq_eq_imm", S_IMM, 32'hFFFFFFFF);
        expect_out("beq_eq_zero", S_ZERO, 32'h1);
        expect_out("beq_eq_wren", S_WR_EN, 32'h0);
        drive(32'h1022FFFF, 1'b1, 32'h0, 1'b0);
        expect_out("beq_ne_taken", S_BRANCH, 32'h0);
        expect_out("beq_ne_addr", S_ADDR, 32'hFFFFFFFE);

        // lw $4,8($1)
        drive(32'h8C240008, 1'b1, 32'hDEADBEEF, 1'b0);
        expect_out("lw_addr", S_ADDR, 32'd13);
        // sw $2,0($4): reads $4 via rs, $2 via rt (beq must not have written $2)
        drive(32'hAC820000, 1'b1, 32'h0, 1'b0);
        expect_out("lw_result", S_ADDR, 32'hDEADBEEF);
        expect_out("beq_no_write", S_WDATA, 32'd7);

        // lw repeated with i_enable=0, then sw with i_enable=0
        drive(32'h8C240008, 1'b0, 32'h12345678, 1'b0);
        expect_out("lw_dis_addr", S_ADDR, 32'd13);
        drive(32'hAC040000, 1'b0, 32'h0, 1'b0);
        expect_out("lw_dis_keep", S_WDATA, 32'hDEADBEEF);
        expect_out("sw_dis_wren", S_WR_EN, 32'h0);

        // addi $0,$0,9 then read $0
        drive(32'h20000009, 1'b1, 32'h0, 1'b0);
        expect_out("addi0_addr", S_ADDR, 32'd9);
        drive(32'hAC000000, 1'b1, 32'h0, 1'b0);
        expect_out("r0_zero", S_WDATA, 32'h0);

        // j with zero and nonzero register fields
        drive(32'h08000010, 1'b1, 32'h0, 1'b0);
        expect_out("j_jump", S_JUMP, 32'h1);
        expect_out("j_wren", S_WR_EN, 32'h0);
        drive(32'h08421800, 1'b1, 32'hCAFEF00D, 1'b0);
        expect_out("j2_jump", S_JUMP, 32'h1);
        expect_out("j2_branch", S_BRANCH, 32'h0);
        // unknown opcode 0x3F, fields rs=1 rt=2 rd=3; ALU add -> 12
        drive(32'hFC221800, 1'b1, 32'hCAFEF00D, 1'b0);
        expect_out("unk_jump", S_JUMP, 32'h0);
        expect_out("unk_wren", S_WR_EN, 32'h0);
        expect_out("unk_branch", S_BRANCH, 32'h0);
        expect_out("unk_addr", S_ADDR, 32'd12);
        // sw $3,0($2): $2 and $3 both still 7
        drive(32'hAC430000, 1'b1, 32'h0, 1'b0);
        expect_out("nowr_r2", S_ADDR, 32'd7);
        expect_out("nowr_r3", S_WDATA, 32'd7);

        // Async reset: write $5, read it, then raise reset mid-cycle
        drive(32'h20050055, 1'b1, 32'h0, 1'b0);
        expect_out("addi5_addr", S_ADDR, 32'h55);
        drive(32'h20A00000, 1'b1, 32'h0, 1'b0);
        expect_out("r5_before", S_ADDR, 32'h55);
        drive(32'h20A00000, 1'b1, 32'h0, 1'b1);
        expect_out("r5_async_rst", S_ADDR, 32'h0);
        // addi $6,$0,3 attempted while reset is high
        drive(32'h20060003, 1'b1, 32'h0, 1'b1);
        expect_out("rst_wr_addr", S_ADDR, 32'd3);
        // sw $6,0($5) after reset release
        drive(32'hACA60000, 1'b1, 32'h0, 1'b0);
        expect_out("r5_cleared", S_ADDR, 32'h0);
        expect_out("r6_ignored", S_WDATA, 32'h0);

        // Let the monitor drain; anything left over is a failure
        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
